ddr_datapath_read: RTL and testbench

Read-side datapath of the DDR controller; the mirror of the write datapath. After a read command it waits out CAS latency, then captures the DDR burst one byte per clk_2x cycle from the DQ pins. It checks DQS toggling on each byte and reassembles byte pairs into 16-bit system words, high byte first, matching write-path byte order. Each word goes to the system side with a one-cycle valid strobe; a done pulse marks the end of the burst.

---
 rtl/ddr_datapath_read_pkg.sv | 30 +++
 rtl/ddr_datapath_read_if.sv | 25 ++
 rtl/ddr_datapath_read_byte_pack.sv | 54 +++++
 rtl/ddr_datapath_read.sv | 114 +++++++++++
 tb/tb_ddr_datapath_read.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_datapath_read_pkg.sv
// Shared types and command-FSM state codes for the DDR read datapath.
// Pure declarations: no latency, no flow control.
package ddr_datapath_read_pkg;

    // Command FSM state codes, common to the whole DDR controller
    localparam int          CMD_W                 = 4;
    localparam logic [3:0]  c_IDLE                = 4'd0;
    localparam logic [3:0]  c_ACTIVATE            = 4'd1;
    localparam logic [3:0]  c_WRITE               = 4'd2;
    localparam logic [3:0]  c_WAIT_END_OF_W_BURST = 4'd3;
    localparam logic [3:0]  c_READ                = 4'd4;
    localparam logic [3:0]  c_WAIT_END_OF_R_BURST = 4'd5;
    localparam logic [3:0]  c_PRECHARGE           = 4'd6;
    localparam logic [3:0]  c_REFRESH             = 4'd7;

    localparam int LAT_W  = 4;
    localparam int BYTE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_CL = 2'd1,
        ST_CAPTURE = 2'd2
    } rd_state_e;

    // DQS is high while even bytes are on the bus, low for odd bytes
    function automatic logic dqs_expected(input logic [BYTE_W-1:0] byte_idx);
        return ~byte_idx[0];
    endfunction

endpackage

// File: rtl/ddr_datapath_read_if.sv
// Pin-side inputs and system-side read results of the DDR read datapath.
// Strobe-only outputs: the system side cannot stall a burst.
interface ddr_datapath_read_if;
    import ddr_datapath_read_pkg::*;

    logic             rden;
    logic [CMD_W-1:0] cmd_state;
    logic [7:0]       ddr_dq_r;
    logic             ddr_dqs_r;
    logic [15:0]      sys_data_r;
    logic             sys_rd_valid;
    logic             rd_done;
    logic             rd_err;

    modport master (
        output rden, cmd_state, ddr_dq_r, ddr_dqs_r,
        input  sys_data_r, sys_rd_valid, rd_done, rd_err
    );

    modport slave (
        input  rden, cmd_state, ddr_dq_r, ddr_dqs_r,
        output sys_data_r, sys_rd_valid, rd_done, rd_err
    );

endinterface

// File: rtl/ddr_datapath_read_byte_pack.sv
// Pairs captured bytes into 16-bit words, high byte first; word and strobe
// appear one cycle after the odd byte is presented. No backpressure.
module ddr_read_byte_pack (
    input  logic        clk_2x,
    input  logic        rst,
    input  logic        byte_stb,
    input  logic        byte_odd,
    input  logic        byte_last,
    input  logic [7:0]  byte_dat,
    output logic [15:0] word_dat,
    output logic        word_vld,
    output logic        word_last
);

    logic [7:0]  hi_q,   hi_d;
    logic [15:0] word_q, word_d;
    logic        vld_q,  vld_d;
    logic        last_q, last_d;

    always_comb begin
        hi_d   = hi_q;
        word_d = word_q;
        vld_d  = 1'b0;
        last_d = 1'b0;
        if (byte_stb) begin
            if (byte_odd) begin
                word_d = {hi_q, byte_dat};
                vld_d  = 1'b1;
                last_d = byte_last;
            end else begin
                hi_d = byte_dat;
            end
        end
    end

    always_ff @(posedge clk_2x or negedge rst) begin
        if (!rst) begin
            hi_q   <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            word_q <= word_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign word_dat  = word_q;
    assign word_vld  = vld_q;
    assign word_last = last_q;

endmodule

// File: rtl/ddr_datapath_read.sv
// DDR read datapath: waits CAS latency, captures a burst from DQ, checks DQS, emits 16-bit words.
// Word j strobes CAS_LAT+2j+3 cycles after the accepted start; no backpressure, rden ignored mid-burst.
module ddr_datapath_read
    import ddr_datapath_read_pkg::*;
#(
    parameter int CAS_LAT     = 6,
    parameter int BURST_BYTES = 8
) (
    input  logic                clk_2x,
    input  logic                rst,
    ddr_datapath_read_if.slave  bus
);

    logic [7:0]        dq_q, dq_d;
    logic              dqs_q, dqs_d;
    rd_state_e         state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic              rd_err_q, rd_err_d;

    logic              cmd_ok;
    logic              byte_stb;
    logic              byte_last;

    assign cmd_ok    = (bus.cmd_state == c_WAIT_END_OF_R_BURST);
    assign byte_last = (byte_cnt_q == BYTE_W'(BURST_BYTES - 1));

    always_comb begin
        dq_d  = bus.ddr_dq_r;
        dqs_d = bus.ddr_dqs_r;
    end

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rd_err_d   = rd_err_q;
        byte_stb   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.rden && cmd_ok) begin
                    state_d    = ST_WAIT_CL;
                    lat_cnt_d  = LAT_W'(CAS_LAT - 1);
                    byte_cnt_d = '0;
                    rd_err_d   = 1'b0;
                end
            end
            ST_WAIT_CL: begin
                if (!cmd_ok) begin
                    state_d  = ST_IDLE;
                    rd_err_d = 1'b1;
                end else if (lat_cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                // An abort drops the byte in flight so no partial word is strobed
                if (!cmd_ok) begin
                    state_d  = ST_IDLE;
                    rd_err_d = 1'b1;
                end else begin
                    byte_stb = 1'b1;
                    if (dqs_q != dqs_expected(byte_cnt_q)) begin
                        rd_err_d = 1'b1;
                    end
                    if (byte_last) begin
                        state_d    = ST_IDLE;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_2x or negedge rst) begin
        if (!rst) begin
            dq_q       <= '0;
            dqs_q      <= 1'b0;
            state_q    <= ST_IDLE;
            lat_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            dq_q       <= dq_d;
            dqs_q      <= dqs_d;
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rd_err_q   <= rd_err_d;
        end
    end

    ddr_read_byte_pack u_byte_pack (
        .clk_2x    (clk_2x),
        .rst       (rst),
        .byte_stb  (byte_stb),
        .byte_odd  (byte_cnt_q[0]),
        .byte_last (byte_last),
        .byte_dat  (dq_q),
        .word_dat  (bus.sys_data_r),
        .word_vld  (bus.sys_rd_valid),
        .word_last (bus.rd_done)
    );

    assign bus.rd_err = rd_err_q;

endmodule

// File: tb/tb_ddr_datapath_read.sv
// Scoreboard bench for ddr_datapath_read: pins driven from a per-cycle schedule,
// expected words queued at burst start and matched against each valid strobe.
module tb_ddr_datapath_read;
    import ddr_datapath_read_pkg::*;

    localparam int CL = 6;
    localparam int BB = 8;

    logic clk_2x = 1'b0;
    logic rst    = 1'b0;

    ddr_datapath_read_if bus();

    ddr_datapath_read #(
        .CAS_LAT     (CL),
        .BURST_BYTES (BB)
    ) dut (
        .clk_2x (clk_2x),
        .rst    (rst),
        .bus    (bus)
    );

    initial forever #5 clk_2x = ~clk_2x;

    typedef struct {
        int          cyc;
        logic [15:0] dat;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [8:0]  pin_sched [int];
    int          cyc       = 0;
    int          tests     = 0;
    int          fails     = 0;
    logic [15:0] last_word = '0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_2x);
        #2;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Call in cycle T0: asserts rden and schedules pins plus expected words
    task automatic start_burst(input logic [7:0] seed, input int bad_byte);
        int         t0;
        logic [7:0] hi;
        logic [7:0] b;
        logic       dqs;
        exp_t       e;
        t0            = cyc;
        hi            = '0;
        bus.rden      = 1'b1;
        bus.cmd_state = c_WAIT_END_OF_R_BURST;
        for (int k = 0; k < BB; k++) begin
            b   = seed + 8'(k * 17);
            dqs = ((k % 2) == 0) || (k == bad_byte);
            pin_sched[t0 + CL + k] = {dqs, b};
            if ((k % 2) == 0) begin
                hi = b;
            end else begin
                e.cyc  = t0 + CL + k + 2;
                e.dat  = {hi, b};
                e.last = (k == BB - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic drop_after(input int c);
        exp_t keep[$];
        foreach (sb[i]) begin
            if (sb[i].cyc <= c) keep.push_back(sb[i]);
        end
        sb = keep;
    endtask

    // Pin driver: scheduled burst bytes, random noise otherwise
    initial begin
        bus.ddr_dq_r  = '0;
        bus.ddr_dqs_r = 1'b0;
        forever begin
            @(posedge clk_2x);
            cyc++;
            #1;
            if (pin_sched.exists(cyc)) begin
                {bus.ddr_dqs_r, bus.ddr_dq_r} = pin_sched[cyc];
            end else begin
                bus.ddr_dq_r  = 8'($urandom);
                bus.ddr_dqs_r = 1'($urandom);
            end
        end
    end

    // Output monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_2x);
            if (!rst) begin
                last_word = '0;
            end else begin
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    check_val("vld_missing_at", 32'(cyc), 32'(sb[0].cyc));
                    void'(sb.pop_front());
                end
                if (bus.sys_rd_valid) begin
                    if (sb.size() > 0 && sb[0].cyc == cyc) begin
                        e = sb.pop_front();
                        check_val("word", 32'(bus.sys_data_r), 32'(e.dat));
                        check_val("rd_done", 32'(bus.rd_done), 32'(e.last));
                    end else begin
                        check_val("spurious_vld_pending", 32'(sb.size() > 0 && sb[0].cyc == cyc), 32'd1);
                    end
                    last_word = bus.sys_data_r;
                end else begin
                    check_val("data_hold", 32'(bus.sys_data_r), 32'(last_word));
                    check_val("done_no_vld", 32'(bus.rd_done), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int t1;
        bus.rden      = 1'b0;
        bus.cmd_state = c_IDLE;
        rst           = 1'b0;
        repeat (4) tick();
        check_val("rst_data", 32'(bus.sys_data_r), 32'd0);
        check_val("rst_vld",  32'(bus.sys_rd_valid), 32'd0);
        check_val("rst_done", 32'(bus.rd_done), 32'd0);
        check_val("rst_err",  32'(bus.rd_err), 32'd0);
        rst = 1'b1;
        repeat (6) tick();
        check_val("idle_vld", 32'(bus.sys_rd_valid), 32'd0);

        // Nominal burst 11..88
        t0 = cyc;
        start_burst(8'h11, -1);
        tick();
        bus.rden = 1'b0;
        wait_until(t0 + CL + BB + 1);
        check_val("nom_done", 32'(bus.rd_done), 32'd1);
        check_val("nom_err",  32'(bus.rd_err), 32'd0);
        repeat (3) tick();

        // DQS stuck high on byte 3
        t0 = cyc;
        start_burst(8'h11, 3);
        tick();
        bus.rden = 1'b0;
        wait_until(t0 + 9);
        check_val("dqs_err_before", 32'(bus.rd_err), 32'd0);
        wait_until(t0 + 11);
        check_val("dqs_err_set", 32'(bus.rd_err), 32'd1);
        wait_until(t0 + CL + BB + 1);
        check_val("dqs_err_held", 32'(bus.rd_err), 32'd1);
        check_val("dqs_done", 32'(bus.rd_done), 32'd1);

        // Back-to-back start in the rd_done cycle; mid-burst rden ignored
        t1 = cyc;
        start_burst(8'hA1, -1);
        tick();
        bus.rden = 1'b0;
        check_val("b2b_err_clr", 32'(bus.rd_err), 32'd0);
        wait_until(t1 + 5);
        bus.rden = 1'b1;
        tick();
        bus.rden = 1'b0;
        wait_until(t1 + 8);
        bus.rden = 1'b1;
        tick();
        bus.rden = 1'b0;
        wait_until(t1 + CL + BB + 1);
        check_val("b2b_done", 32'(bus.rd_done), 32'd1);
        check_val("b2b_err",  32'(bus.rd_err), 32'd0);
        repeat (2) tick();

        // Abort after the first word
        t0 = cyc;
        start_burst(8'h11, -1);
        tick();
        bus.rden = 1'b0;
        wait_until(t0 + 10);
        bus.cmd_state = c_IDLE;
        drop_after(t0 + 10);
        tick();
        check_val("abort_err", 32'(bus.rd_err), 32'd1);
        wait_until(t0 + CL + BB + 3);
        check_val("abort_err_held", 32'(bus.rd_err), 32'd1);

        // Async reset mid-burst with rd_err already set
        tick();
        t0 = cyc;
        start_burst(8'h5A, 1);
        tick();
        bus.rden = 1'b0;
        wait_until(t0 + 11);
        check_val("pre_rst_err", 32'(bus.rd_err), 32'd1);
        wait_until(t0 + 12);
        rst = 1'b0;
        sb.delete();
        #1;
        check_val("arst_data", 32'(bus.sys_data_r), 32'd0);
        check_val("arst_vld",  32'(bus.sys_rd_valid), 32'd0);
        check_val("arst_done", 32'(bus.rd_done), 32'd0);
        check_val("arst_err",  32'(bus.rd_err), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Fresh burst after reset
        t0 = cyc;
        start_burst(8'h3C, -1);
        tick();
        bus.rden = 1'b0;
        wait_until(t0 + CL + BB + 1);
        check_val("post_rst_done", 32'(bus.rd_done), 32'd1);
        check_val("post_rst_err",  32'(bus.rd_err), 32'd0);
        repeat (4) tick();
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
